// File: rtl/via_n_m_if.sv
// Handshake bundle for via_n_m: NUM_IN buffered sink channels in, NUM_OUT source channels out.
// The DUT side uses the slave modport; the traffic generator side uses master.
interface via_n_m_if #(
  parameter int WIDTH        = 32,
  parameter int NUM_IN       = 2,
  parameter int NUM_OUT      = 2,
  parameter int N_ADDR_WIDTH = 4
);
  logic [NUM_IN*WIDTH-1:0]         i_data_in;
  logic [NUM_IN-1:0]               i_valid_in;
  logic [NUM_IN-1:0]               i_ready_out;
  logic [NUM_OUT*WIDTH-1:0]        o_data_out;
  logic [NUM_OUT*N_ADDR_WIDTH-1:0] o_dest_out;
  logic [NUM_OUT-1:0]              o_valid_out;
  logic [NUM_OUT-1:0]              o_ready_in;

  modport master (
    output i_data_in, i_valid_in, o_ready_in,
    input  i_ready_out, o_data_out, o_dest_out, o_valid_out
  );

  modport slave (
    input  i_data_in, i_valid_in, o_ready_in,
    output i_ready_out, o_data_out, o_dest_out, o_valid_out
  );
endinterface

// File: rtl/via_n_m.sv
// Multi-input/multi-output dependency point: fires once every input holds a flit and all outputs are ready.
// Optional macro VIA_SEQ_CHECK_EN enables per-input sequence checking that drives the sticky err flag.
module via_n_m #(
  parameter int                                    WIDTH        = 32,
  parameter int                                    N            = 16,
  parameter int                                    N_ADDR_WIDTH = $clog2(N),
  parameter int                                    NUM_IN       = 2,
  parameter int                                    NUM_OUT      = 2,
  parameter int                                    DEPTH        = 4,
  parameter int                                    NODE         = 15,
  parameter logic [NUM_OUT*8-1:0]                  O_ID         = {NUM_OUT{8'd0}},
  parameter logic [NUM_IN*8-1:0]                   I_ID         = {NUM_IN{8'd0}},
  parameter int                                    NUM_DEST     = 4,
  parameter logic [NUM_OUT*NUM_DEST*N_ADDR_WIDTH-1:0] O_DEST    = '1,
  parameter bit                                    NODEP        = 1'b0,
  parameter int                                    DONE_COUNT   = 1000
) (
  input  logic     clk,
  input  logic     rst,
  output logic     done,
  output logic     err,
  via_n_m_if.slave bus
);

  localparam int CW  = WIDTH - 2*N_ADDR_WIDTH - 8;
  localparam int PW  = $clog2(DEPTH);
  localparam int DCW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [N_ADDR_WIDTH-1:0] NODE_A = N_ADDR_WIDTH'(NODE);

  // Per-input buffer state
  logic [CW-1:0] mem_q     [NUM_IN][DEPTH];
  logic [PW-1:0] wr_ptr_q  [NUM_IN];
  logic [PW-1:0] rd_ptr_q  [NUM_IN];
  logic [PW:0]   count_q   [NUM_IN];
  logic [PW:0]   count_d   [NUM_IN];
  logic [CW-1:0] rc_q      [NUM_IN];

  // Output-side state
  logic [CW-1:0]                   fc_q;
  logic [CW-1:0]                   fc_d;
  logic [DCW-1:0]                  dstcount_q [NUM_OUT];
  logic [N_ADDR_WIDTH-1:0]         dest_sel   [NUM_OUT];
  logic [NUM_OUT*WIDTH-1:0]        o_data_q;
  logic [NUM_OUT*N_ADDR_WIDTH-1:0] o_dest_q;
  logic [NUM_OUT-1:0]              o_valid_q;
  logic                            done_q;

  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic              all_nonempty;
  logic              all_rc_over;
  logic              fire;
  logic              unused_fold;

  // NOTE: every variable assigned in always_comb gets a default before any condition, so no latch is inferred.
  always_comb begin
    all_nonempty = 1'b1;
    all_rc_over  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      all_nonempty = all_nonempty & (count_q[k] != '0);
      all_rc_over  = all_rc_over & (32'(rc_q[k]) > DONE_COUNT);
    end
  end

  assign fire = (&bus.o_ready_in) && (NODEP || all_nonempty);
  assign fc_d = fc_q + 1'b1;

  // Ready comes from the registered fill level; reset forces it low while asserted.
  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      bus.i_ready_out[k] = !rst && (count_q[k] != (PW+1)'(DEPTH));
      push[k]            = bus.i_valid_in[k] && bus.i_ready_out[k];
      pop[k]             = fire && (count_q[k] != '0);
      count_d[k]         = count_q[k] + (PW+1)'(push[k]) - (PW+1)'(pop[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      dest_sel[k] = O_DEST[(k*NUM_DEST + int'(dstcount_q[k]))*N_ADDR_WIDTH +: N_ADDR_WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_IN; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
        rc_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        count_q[k] <= count_d[k];
        if (push[k]) begin
          wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
          rc_q[k]     <= rc_q[k] + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        end
      end
    end
  end

  // NOTE: buffer storage has no reset; pointers and counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= bus.i_data_in[k*WIDTH +: CW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q      <= '0;
      o_data_q  <= '0;
      o_dest_q  <= '0;
      o_valid_q <= '0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        dstcount_q[k] <= '0;
      end
    end else begin
      o_valid_q <= {NUM_OUT{fire}};
      done_q    <= (32'(fc_q) > DONE_COUNT) && all_rc_over;
      if (fire) begin
        fc_q <= fc_d;
        for (int k = 0; k < NUM_OUT; k++) begin
          o_dest_q[k*N_ADDR_WIDTH +: N_ADDR_WIDTH] <= dest_sel[k];
          o_data_q[k*WIDTH +: WIDTH]               <= {NODE_A, dest_sel[k], O_ID[k*8 +: 8], fc_d};
          dstcount_q[k] <= (dstcount_q[k] == DCW'(NUM_DEST-1)) ? '0 : dstcount_q[k] + 1'b1;
        end
      end
    end
  end

  assign bus.o_data_out  = o_data_q;
  assign bus.o_dest_out  = o_dest_q;
  assign bus.o_valid_out = o_valid_q;
  assign done            = done_q;

`ifdef VIA_SEQ_CHECK_EN
  logic [CW-1:0] expected_q [NUM_IN];
  logic          err_q;

  // A gap flags once: the expectation resyncs to whatever count actually arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
        expected_q[k] <= CW'(1);
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (push[k]) begin
          if ((bus.i_data_in[k*WIDTH +: CW] != expected_q[k]) ||
              (bus.i_data_in[k*WIDTH + CW + 8 +: N_ADDR_WIDTH] != NODE_A)) begin
            err_q <= 1'b1;
          end
          expected_q[k] <= bus.i_data_in[k*WIDTH +: CW] + 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Buffered payload and routing fields are carried for the model but never drive an output.
  always_comb begin
    unused_fold = ^bus.i_data_in ^ ^I_ID;
    for (int k = 0; k < NUM_IN; k++) begin
      unused_fold = unused_fold ^ (^mem_q[k][rd_ptr_q[k]]);
    end
  end

endmodule

// File: tb/tb_via_n_m.sv
// Scoreboard bench for via_n_m: driver predicts firings into a queue, a negedge monitor checks outputs.
module tb_via_n_m;
  localparam int W     = 32;
  localparam int AW    = 4;
  localparam int NI    = 2;
  localparam int NO    = 2;
  localparam int DEPTH = 4;
  localparam int ND    = 3;
  localparam int DC    = 6;
  localparam int CW    = 16;
  localparam logic [NO*ND*AW-1:0] ODEST = {4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd3};
  localparam logic [NO*8-1:0]     OID   = {8'hB1, 8'hA0};

  typedef struct {
    logic [NO*W-1:0]  data;
    logic [NO*AW-1:0] dest;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic done;
  logic err;

  via_n_m_if #(.WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO), .N_ADDR_WIDTH(AW)) bus ();

  via_n_m #(
    .WIDTH(W), .N(16), .N_ADDR_WIDTH(AW), .NUM_IN(NI), .NUM_OUT(NO), .DEPTH(DEPTH),
    .NODE(15), .O_ID(OID), .I_ID(16'h0000), .NUM_DEST(ND), .O_DEST(ODEST),
    .NODEP(1'b0), .DONE_COUNT(DC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .err  (err),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];

  // Hand-written routing tables, independent of the packed parameter layout.
  int         dtab [NO][ND] = '{'{3, 5, 7}, '{9, 11, 13}};
  logic [7:0] ids  [NO]     = '{8'hA0, 8'hB1};

  // Reference model state
  int            cnt   [NI];
  int            rc_m  [NI];
  int            dc_m  [NO];
  logic [CW-1:0] exp_m [NI];
  logic [CW-1:0] nxt   [NI];
  logic [AW-1:0] dstf  [NI];
  logic          offer [NI];
  int            fc_m;
  logic          err_m;
  logic          done_m;

  logic [NO*W-1:0]  last_data;
  logic [NO*AW-1:0] last_dest;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      cnt[k]   = 0;
      rc_m[k]  = 0;
      exp_m[k] = 16'd1;
      nxt[k]   = 16'd1;
    end
    for (int k = 0; k < NO; k++) dc_m[k] = 0;
    fc_m   = 0;
    err_m  = 1'b0;
    done_m = 1'b0;
    sb.delete();
  endtask

  // One clock: drive, check registered flags, predict the edge, advance.
  task automatic cycle();
    logic [NI-1:0] push;
    logic          fire;
    logic          dn;
    exp_t          e;
    for (int k = 0; k < NI; k++) begin
      bus.i_valid_in[k]        = offer[k];
      bus.i_data_in[k*W +: W]  = {4'd3, dstf[k], 8'h00, nxt[k]};
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("ready%0d", k), 64'(bus.i_ready_out[k]), 64'(!rst && cnt[k] != DEPTH));
    end
    check("done", 64'(done), 64'(done_m));
    check("err", 64'(err), 64'(err_m));

    fire = !rst && (&bus.o_ready_in);
    dn   = !rst && (fc_m > DC);
    for (int k = 0; k < NI; k++) begin
      if (cnt[k] == 0) fire = 1'b0;
      if (rc_m[k] <= DC) dn = 1'b0;
      push[k] = !rst && offer[k] && (cnt[k] != DEPTH);
    end

    if (fire) begin
      fc_m++;
      e.data = '0;
      e.dest = '0;
      for (int k = 0; k < NO; k++) begin
        e.dest[k*AW +: AW] = AW'(dtab[k][dc_m[k]]);
        e.data[k*W +: W]   = {4'd15, AW'(dtab[k][dc_m[k]]), ids[k], CW'(fc_m)};
        dc_m[k] = (dc_m[k] == ND-1) ? 0 : dc_m[k] + 1;
      end
      e.cyc = cyc + 1;
      sb.push_back(e);
    end

    for (int k = 0; k < NI; k++) begin
      if (push[k]) begin
`ifdef VIA_SEQ_CHECK_EN
        if (nxt[k] != exp_m[k] || dstf[k] != 4'd15) err_m = 1'b1;
        exp_m[k] = nxt[k] + 16'd1;
`endif
        rc_m[k]++;
        cnt[k]++;
      end
      if (fire) cnt[k]--;
    end

    @(posedge clk);
    done_m = dn;
    for (int k = 0; k < NI; k++) if (push[k]) nxt[k] = nxt[k] + 16'd1;
    @(negedge clk);
  endtask

  task automatic set_offer(input logic a, input logic b);
    offer[0] = a;
    offer[1] = b;
  endtask

  // Monitor: a queued entry tagged for this cycle must appear; otherwise outputs must be idle and held.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
      last_dest = '0;
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("o_valid", 64'(bus.o_valid_out), 64'({NO{1'b1}}));
      check("o_data", 64'(bus.o_data_out), 64'(e.data));
      check("o_dest", 64'(bus.o_dest_out), 64'(e.dest));
      last_data = e.data;
      last_dest = e.dest;
    end else begin
      check("o_valid_idle", 64'(bus.o_valid_out), 64'(0));
      check("o_data_hold", 64'(bus.o_data_out), 64'(last_data));
      check("o_dest_hold", 64'(bus.o_dest_out), 64'(last_dest));
    end
  end

  initial begin
    rst = 1'b1;
    bus.i_valid_in = '0;
    bus.i_data_in  = '0;
    bus.o_ready_in = 2'b11;
    dstf[0] = 4'd15;
    dstf[1] = 4'd15;
    set_offer(1'b0, 1'b0);
    model_clear();

    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;

    // Only input 0 holds data: no firing until input 1 arrives.
    set_offer(1'b1, 1'b0);
    repeat (2) cycle();
    set_offer(1'b0, 1'b0);
    cycle();
    set_offer(1'b0, 1'b1);
    cycle();
    set_offer(1'b0, 1'b0);
    repeat (2) cycle();

    // Fill input 0 until ready drops, then release one slot through input 1.
    set_offer(1'b1, 1'b0);
    repeat (6) cycle();
    set_offer(1'b1, 1'b1);
    cycle();
    set_offer(1'b1, 1'b0);
    repeat (3) cycle();

    // Back-to-back firings walk the destination rotation.
    set_offer(1'b1, 1'b1);
    repeat (9) cycle();
    set_offer(1'b0, 1'b0);
    repeat (2) cycle();

    // Partial output readiness stalls every output.
    bus.o_ready_in = 2'b01;
    set_offer(1'b1, 1'b1);
    repeat (6) cycle();
    set_offer(1'b0, 1'b0);
    repeat (2) cycle();
    bus.o_ready_in = 2'b11;
    repeat (2) cycle();
    bus.o_ready_in = 2'b00;
    set_offer(1'b1, 1'b1);
    cycle();
    set_offer(1'b0, 1'b0);

    // Mid-stream reset with three entries buffered per input.
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.o_valid_out), 64'(0));
    check("rst_data", 64'(bus.o_data_out), 64'(0));
    check("rst_ready", 64'(bus.i_ready_out), 64'(0));
    model_clear();
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;
    bus.o_ready_in = 2'b11;
    repeat (2) cycle();
    set_offer(1'b1, 1'b1);
    cycle();
    set_offer(1'b0, 1'b0);
    repeat (2) cycle();

    // Sequence gap on input 0: counts 1, 2, 4.
    set_offer(1'b1, 1'b1);
    cycle();
    nxt[0] = 16'd4;
    cycle();
    set_offer(1'b0, 1'b0);
    repeat (3) cycle();

    // Sustained traffic drives both counters past the done threshold.
    set_offer(1'b1, 1'b1);
    repeat (10) cycle();
    set_offer(1'b0, 1'b0);
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
